// File: rtl/key_search_pkg.sv
// Shared types and default sizing for the RC4 key search controller.
package key_search_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LAUNCH    = 3'd1,
    ST_RUN       = 3'd2,
    ST_FOUND     = 3'd3,
    ST_EXHAUSTED = 3'd4
  } state_e;

  localparam int KEY_WIDTH_DEF        = 22;
  localparam int CORE_COUNT_LOG_2_DEF = 3;
  localparam int CYC_WIDTH_DEF        = 32;

endpackage

// File: rtl/lsb_priority_encoder.sv
// Lowest-index-wins priority encoder: reports the smallest set bit of i_req.
module lsb_priority_encoder #(
  parameter int WIDTH = 8,
  parameter int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] i_req,
  output logic [IDX_W-1:0] o_index,
  output logic             o_valid
);

  logic [IDX_W-1:0] w_idx;

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    w_idx = {IDX_W{1'b0}};
    for (int i = WIDTH - 1; i >= 0; i--) begin
      w_idx = i_req[i] ? IDX_W'(i) : w_idx;
    end
  end

  assign o_index = w_idx;
  assign o_valid = |i_req;

endmodule

// File: rtl/key_search_controller.sv
// Launches a bank of RC4 cracking cores, watches for a hit or exhaustion,
// and holds the winning key, core index and elapsed cycle count.
module key_search_controller
  import key_search_pkg::*;
#(
  parameter  int CORE_COUNT_LOG_2 = CORE_COUNT_LOG_2_DEF,
  parameter  int KEY_WIDTH        = KEY_WIDTH_DEF,
  parameter  int CYC_WIDTH        = CYC_WIDTH_DEF,
  localparam int CORE_COUNT       = 2 ** CORE_COUNT_LOG_2
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            start,
  input  logic [CORE_COUNT-1:0]           core_found,
  input  logic [CORE_COUNT-1:0]           core_done,
  input  logic [CORE_COUNT*KEY_WIDTH-1:0] core_key,
  input  logic [CORE_COUNT_LOG_2-1:0]     display_sel,
  output logic [CORE_COUNT-1:0]           core_start,
  output logic                            stop_all,
  output logic                            key_valid,
  output logic [KEY_WIDTH-1:0]            found_key,
  output logic [CORE_COUNT_LOG_2-1:0]     found_core,
  output logic                            exhausted,
  output logic                            busy,
  output logic [CYC_WIDTH-1:0]            cycle_count,
  output logic [KEY_WIDTH-1:0]            display_key
);

  state_e                        r_state;
  state_e                        w_state_nxt;
  logic                          r_start_q;
  logic                          r_armed;
  logic                          w_launch;
  logic [CORE_COUNT_LOG_2-1:0]   w_win_idx;
  logic                          w_win_valid;
  logic [KEY_WIDTH-1:0]          w_keys [CORE_COUNT];
  logic [KEY_WIDTH-1:0]          w_win_key;
  logic [CYC_WIDTH-1:0]          w_cyc_inc;

  logic [CORE_COUNT-1:0]         r_core_start;
  logic                          r_stop_all;
  logic                          r_key_valid;
  logic [KEY_WIDTH-1:0]          r_found_key;
  logic [CORE_COUNT_LOG_2-1:0]   r_found_core;
  logic                          r_exhausted;
  logic                          r_busy;
  logic [CYC_WIDTH-1:0]          r_cycle_count;
  logic [KEY_WIDTH-1:0]          r_display_key;

  for (genvar g = 0; g < CORE_COUNT; g++) begin : g_unpack
    assign w_keys[g] = core_key[g*KEY_WIDTH +: KEY_WIDTH];
  end

  lsb_priority_encoder #(
    .WIDTH (CORE_COUNT),
    .IDX_W (CORE_COUNT_LOG_2)
  ) u_win_enc (
    .i_req   (core_found),
    .o_index (w_win_idx),
    .o_valid (w_win_valid)
  );

  assign w_win_key = w_keys[w_win_idx];
  assign w_cyc_inc = (&r_cycle_count) ? r_cycle_count : r_cycle_count + CYC_WIDTH'(1);
  // r_armed stays low until start is seen low, so a level held through reset cannot launch.
  assign w_launch  = start & ~r_start_q & r_armed;

  // State register and start edge detector.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_IDLE;
      r_start_q <= 1'b0;
      r_armed   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_start_q <= start;
      r_armed   <= r_armed | ~start;
    end
  end

  // Next-state decode; core flags are only consulted in RUN.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_launch) w_state_nxt = ST_LAUNCH;
        else          w_state_nxt = ST_IDLE;
      end
      ST_LAUNCH: w_state_nxt = ST_RUN;
      ST_RUN: begin
        if (w_win_valid)     w_state_nxt = ST_FOUND;
        else if (&core_done) w_state_nxt = ST_EXHAUSTED;
        else                 w_state_nxt = ST_RUN;
      end
      ST_FOUND, ST_EXHAUSTED: begin
        if (!start) w_state_nxt = ST_IDLE;
        else        w_state_nxt = r_state;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Registered outputs, decoded from the state being entered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_core_start  <= {CORE_COUNT{1'b0}};
      r_stop_all    <= 1'b0;
      r_key_valid   <= 1'b0;
      r_found_key   <= {KEY_WIDTH{1'b0}};
      r_found_core  <= {CORE_COUNT_LOG_2{1'b0}};
      r_exhausted   <= 1'b0;
      r_busy        <= 1'b0;
      r_cycle_count <= {CYC_WIDTH{1'b0}};
      r_display_key <= {KEY_WIDTH{1'b0}};
    end else begin
      r_core_start <= (w_state_nxt == ST_LAUNCH) ? {CORE_COUNT{1'b1}} : {CORE_COUNT{1'b0}};
      r_busy       <= (w_state_nxt == ST_LAUNCH) || (w_state_nxt == ST_RUN);
      r_stop_all   <= (w_state_nxt == ST_FOUND) || (w_state_nxt == ST_EXHAUSTED);

      if ((r_state == ST_IDLE) && w_launch) begin
        r_cycle_count <= {CYC_WIDTH{1'b0}};
        r_key_valid   <= 1'b0;
        r_exhausted   <= 1'b0;
        r_found_key   <= {KEY_WIDTH{1'b0}};
        r_found_core  <= {CORE_COUNT_LOG_2{1'b0}};
      end else if (r_state == ST_RUN) begin
        r_cycle_count <= w_cyc_inc;
        if (w_win_valid) begin
          r_found_core <= w_win_idx;
          r_found_key  <= w_win_key;
          r_key_valid  <= 1'b1;
        end else if (&core_done) begin
          r_exhausted <= 1'b1;
        end else begin
          r_exhausted <= r_exhausted;
        end
      end else begin
        r_cycle_count <= r_cycle_count;
      end

      case (w_state_nxt)
        ST_RUN:   r_display_key <= w_keys[display_sel];
        ST_FOUND: r_display_key <= (r_state == ST_RUN) ? w_win_key : r_found_key;
        default:  r_display_key <= {KEY_WIDTH{1'b0}};
      endcase
    end
  end

  assign core_start  = r_core_start;
  assign stop_all    = r_stop_all;
  assign key_valid   = r_key_valid;
  assign found_key   = r_found_key;
  assign found_core  = r_found_core;
  assign exhausted   = r_exhausted;
  assign busy        = r_busy;
  assign cycle_count = r_cycle_count;
  assign display_key = r_display_key;

endmodule

// File: tb/tb_key_search_controller.sv
// Scoreboard bench: stimulus queues expected output snapshots, a negedge monitor
// pops and compares them on every launch/result/return-to-idle event or probe.
module tb_key_search_controller;

  typedef struct {
    string       name;
    logic [7:0]  cs;
    logic        stop;
    logic        kv;
    logic        ex;
    logic        bz;
    logic [21:0] key;
    logic [2:0]  core;
    logic [31:0] cyc;
    logic [21:0] disp;
    logic [3:0]  cyc4;
  } exp_t;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [7:0]  core_found;
  logic [7:0]  core_done;
  logic [175:0] core_key;
  logic [2:0]  display_sel;
  logic        probe;

  logic [7:0]  core_start, core_start2;
  logic        stop_all, stop_all2, key_valid, key_valid2, exhausted, exhausted2, busy, busy2;
  logic [21:0] found_key, found_key2, display_key, display_key2;
  logic [2:0]  found_core, found_core2;
  logic [31:0] cycle_count;
  logic [3:0]  cycle_count2;

  logic [21:0] keys [8] = '{22'h000AAA, 22'h001BBB, 22'h0ABCDE, 22'h003DDD,
                            22'h004EEE, 22'h011111, 22'h006123, 22'h3FFFFF};

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_mis = 0;

  key_search_controller dut (
    .clk(clk), .reset_n(reset_n), .start(start), .core_found(core_found),
    .core_done(core_done), .core_key(core_key), .display_sel(display_sel),
    .core_start(core_start), .stop_all(stop_all), .key_valid(key_valid),
    .found_key(found_key), .found_core(found_core), .exhausted(exhausted),
    .busy(busy), .cycle_count(cycle_count), .display_key(display_key)
  );

  key_search_controller #(.CYC_WIDTH(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .start(start), .core_found(core_found),
    .core_done(core_done), .core_key(core_key), .display_sel(display_sel),
    .core_start(core_start2), .stop_all(stop_all2), .key_valid(key_valid2),
    .found_key(found_key2), .found_core(found_core2), .exhausted(exhausted2),
    .busy(busy2), .cycle_count(cycle_count2), .display_key(display_key2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t mk(string n, logic [7:0] cs, logic st, logic kv, logic ex,
                              logic bz, logic [21:0] k, logic [2:0] c, logic [31:0] cy,
                              logic [21:0] d, logic [3:0] c4);
    exp_t e;
    e.name = n; e.cs = cs; e.stop = st; e.kv = kv; e.ex = ex; e.bz = bz;
    e.key = k; e.core = c; e.cyc = cy; e.disp = d; e.cyc4 = c4;
    return e;
  endfunction

  task automatic cmp(input string nm, input string f, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_mis++;
      $display("FAIL %s.%s actual=%0h required=%0h", nm, f, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_probe(input exp_t e);
    sb.push_back(e);
    probe = 1'b1;
    @(negedge clk);
    #1;
    probe = 1'b0;
  endtask

  // Monitor: compare the full output snapshot on each event against the queue head.
  initial begin
    logic pkv, pex, pstop, trig;
    exp_t e;
    pkv = 1'b0; pex = 1'b0; pstop = 1'b0;
    forever begin
      @(negedge clk);
      trig = probe | (core_start != 8'h00) | (key_valid & ~pkv) | (exhausted & ~pex) | (~stop_all & pstop);
      if (trig) begin
        if (sb.size() == 0) begin
          n_cmp++; n_mis++;
          $display("FAIL unexpected_event actual=cs:%0h kv:%0b ex:%0b stop:%0b required=none", core_start, key_valid, exhausted, stop_all);
        end else begin
          e = sb.pop_front();
          cmp(e.name, "core_start", 32'(core_start), 32'(e.cs));
          cmp(e.name, "stop_all", 32'(stop_all), 32'(e.stop));
          cmp(e.name, "key_valid", 32'(key_valid), 32'(e.kv));
          cmp(e.name, "exhausted", 32'(exhausted), 32'(e.ex));
          cmp(e.name, "busy", 32'(busy), 32'(e.bz));
          cmp(e.name, "found_key", 32'(found_key), 32'(e.key));
          cmp(e.name, "found_core", 32'(found_core), 32'(e.core));
          cmp(e.name, "cycle_count", cycle_count, e.cyc);
          cmp(e.name, "display_key", 32'(display_key), 32'(e.disp));
          cmp(e.name, "w4_cycle_count", 32'(cycle_count2), 32'(e.cyc4));
          cmp(e.name, "w4_core_start", 32'(core_start2), 32'(e.cs));
          cmp(e.name, "w4_stop_all", 32'(stop_all2), 32'(e.stop));
          cmp(e.name, "w4_key_valid", 32'(key_valid2), 32'(e.kv));
          cmp(e.name, "w4_exhausted", 32'(exhausted2), 32'(e.ex));
          cmp(e.name, "w4_busy", 32'(busy2), 32'(e.bz));
          cmp(e.name, "w4_found_key", 32'(found_key2), 32'(e.key));
          cmp(e.name, "w4_found_core", 32'(found_core2), 32'(e.core));
          cmp(e.name, "w4_display_key", 32'(display_key2), 32'(e.disp));
        end
      end
      pkv = key_valid; pex = exhausted; pstop = stop_all;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n = 1'b1; start = 1'b0; core_found = 8'h00; core_done = 8'h00;
    display_sel = 3'd0; probe = 1'b0;
    for (int i = 0; i < 8; i++) core_key[i*22 +: 22] = keys[i];
    #1 reset_n = 1'b0;
    step(); step();
    do_probe(mk("reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 22'h0, 3'd0, 32'd0, 22'h0, 4'h0));
    step(); reset_n = 1'b1;
    step(); step();

    // Launch, RUN start, display latency, then a hit on cores 2 and 5 after 100 RUN cycles.
    start = 1'b1;
    sb.push_back(mk("launch1", 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 22'h0, 3'd0, 32'd0, 22'h0, 4'h0));
    step(); step();
    do_probe(mk("run_start", 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 22'h0, 3'd0, 32'd0, 22'h000AAA, 4'h0));
    step(); display_sel = 3'd5;
    do_probe(mk("disp_latency", 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 22'h0, 3'd0, 32'd1, 22'h000AAA, 4'h1));
    step();
    do_probe(mk("disp_sel5", 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 22'h0, 3'd0, 32'd2, 22'h011111, 4'h2));
    repeat (97) step();
    core_found = 8'b0010_0100;
    sb.push_back(mk("found", 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 22'h0ABCDE, 3'd2, 32'd100, 22'h0ABCDE, 4'hF));
    step();
    core_done = 8'hFF;
    repeat (4) step();
    do_probe(mk("found_hold", 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 22'h0ABCDE, 3'd2, 32'd100, 22'h0ABCDE, 4'hF));
    start = 1'b0; core_found = 8'h00; core_done = 8'h00;
    sb.push_back(mk("found_idle", 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 22'h0ABCDE, 3'd2, 32'd100, 22'h0, 4'hF));
    step(); step();

    // Relaunch clears results; a start edge inside RUN is ignored; all cores exhaust.
    start = 1'b1;
    sb.push_back(mk("launch2", 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 22'h0, 3'd0, 32'd0, 22'h0, 4'h0));
    step(); step();
    start = 1'b0; step();
    start = 1'b1; step();
    core_done = 8'hFF;
    sb.push_back(mk("exhaust", 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 22'h0, 3'd0, 32'd3, 22'h0, 4'h3));
    step();
    repeat (3) step();
    do_probe(mk("exhaust_hold", 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 22'h0, 3'd0, 32'd3, 22'h0, 4'h3));
    start = 1'b0; core_done = 8'h00;
    sb.push_back(mk("exh_idle", 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 22'h0, 3'd0, 32'd3, 22'h0, 4'h3));
    step(); step();
    core_found = 8'h01; core_done = 8'hFF;
    repeat (3) step();
    do_probe(mk("idle_ignore", 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 22'h0, 3'd0, 32'd3, 22'h0, 4'h3));
    core_found = 8'h00; core_done = 8'h00;
    step();

    // Found and all-done in the same cycle: found wins, core 7 with the maximum key.
    start = 1'b1;
    sb.push_back(mk("launch3", 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 22'h0, 3'd0, 32'd0, 22'h0, 4'h0));
    step(); step();
    core_found = 8'h80; core_done = 8'hFF;
    sb.push_back(mk("priority", 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 22'h3FFFFF, 3'd7, 32'd1, 22'h3FFFFF, 4'h1));
    step(); step();
    start = 1'b0; core_found = 8'h00; core_done = 8'h00;
    sb.push_back(mk("prio_idle", 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 22'h3FFFFF, 3'd7, 32'd1, 22'h0, 4'h1));
    step(); step();

    // Reset mid-RUN with start held high through release.
    start = 1'b1;
    sb.push_back(mk("launch4", 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 22'h0, 3'd0, 32'd0, 22'h0, 4'h0));
    step(); step(); step(); step();
    reset_n = 1'b0;
    do_probe(mk("reset_mid", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 22'h0, 3'd0, 32'd0, 22'h0, 4'h0));
    step(); step();
    reset_n = 1'b1;
    repeat (3) step();
    do_probe(mk("no_relaunch", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 22'h0, 3'd0, 32'd0, 22'h0, 4'h0));
    start = 1'b0; step();
    start = 1'b1;
    sb.push_back(mk("launch5", 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 22'h0, 3'd0, 32'd0, 22'h0, 4'h0));
    step(); step(); step(); step();
    do_probe(mk("run_after_reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 22'h0, 3'd0, 32'd2, 22'h011111, 4'h2));
    step(); step();

    while (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      n_cmp++; n_mis++;
      $display("FAIL %s.event actual=missing required=present", e.name);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
